// File: rtl/tdr_pkg.sv
// rtl/tdr_pkg.sv - shared state encoding, timing defaults and control decode for ring_osc_ctrl
package tdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int SETTLE_CYC = 4;
  localparam int DRAIN_CYC  = 3;

  typedef struct packed {
    logic rstb;
    logic tsc;
    logic re;
    logic busy;
    logic valid;
  } ctrl_t;

  // Oscillator pin levels and status flags for each state; carry_b is handled
  // separately because it also depends on saturation.
  function automatic ctrl_t ctrl_for(state_t s);
    ctrl_t c;
    c = '{rstb: 1'b0, tsc: 1'b0, re: 1'b1, busy: 1'b0, valid: 1'b0};
    case (s)
      ST_SETTLE, ST_RUN: c = '{rstb: 1'b1, tsc: 1'b1, re: 1'b0, busy: 1'b1, valid: 1'b0};
      ST_DRAIN:          c = '{rstb: 1'b1, tsc: 1'b0, re: 1'b1, busy: 1'b1, valid: 1'b0};
      ST_DONE:           c = '{rstb: 1'b0, tsc: 1'b0, re: 1'b1, busy: 1'b1, valid: 1'b1};
      default:           c = '{rstb: 1'b0, tsc: 1'b0, re: 1'b1, busy: 1'b0, valid: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tdr_edge_sync.sv
// rtl/tdr_edge_sync.sv - two-flop synchronizer plus rising-edge detector for the ring output
module tdr_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic ring,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Bring the asynchronous ring into the clk domain and keep one delayed copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= ring;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/ring_osc_ctrl.sv
// rtl/ring_osc_ctrl.sv - ring oscillator measurement controller: settle, count edges over a window, report
module ring_osc_ctrl
  import tdr_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             ring_i,
  output logic             ring_rstb_o,
  output logic             ring_tsc_o,
  output logic             ring_carry_b_o,
  output logic             ring_re_o,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WIN_W-1:0] SETTLE_LD = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] DRAIN_LD  = WIN_W'(DRAIN_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl;
  logic [WIN_W-1:0] tmr;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             carry_b;
  logic             rise;
  logic             counting;
  logic             sat_hit;

  tdr_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .ring (ring_i),
    .rise (rise)
  );

  // Edges that reach the detector during RUN or DRAIN are counted; the DRAIN
  // phase lets edges still in the synchronizer pipeline land.
  assign counting = rise && ((state == ST_RUN) || (state == ST_DRAIN));
  assign sat_hit  = counting && (cnt == CNT_MAX);

  // Next-state decode; each timed phase ends when the down-counter hits zero
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_i && (win_len_i != '0)) state_nxt = ST_SETTLE;
      ST_SETTLE: if (tmr == '0) state_nxt = ST_RUN;
      ST_RUN:    if (tmr == '0) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (tmr == '0) state_nxt = ST_DONE;
      ST_DONE:   if (ready_i) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Measurement FSM with phase timer, saturating counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ctrl    <= ctrl_for(ST_IDLE);
      tmr     <= '0;
      win_q   <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      carry_b <= 1'b1;
    end else begin
      state   <= state_nxt;
      ctrl    <= ctrl_for(state_nxt);
      carry_b <= (state_nxt == ST_IDLE) ? 1'b1 : (sat_hit ? 1'b0 : carry_b);
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_SETTLE) begin
            win_q <= win_len_i;
            tmr   <= SETTLE_LD;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        ST_SETTLE: tmr <= (tmr == '0) ? (win_q - 1'b1) : (tmr - 1'b1);
        ST_RUN:    tmr <= (tmr == '0) ? DRAIN_LD : (tmr - 1'b1);
        ST_DRAIN:  if (tmr != '0) tmr <= tmr - 1'b1;
        default:   tmr <= tmr;
      endcase
      if (counting) begin
        if (sat_hit) ovf <= 1'b1;
        else         cnt <= cnt + 1'b1;
      end
    end
  end

  assign ring_rstb_o    = ctrl.rstb;
  assign ring_tsc_o     = ctrl.tsc;
  assign ring_re_o      = ctrl.re;
  assign busy_o         = ctrl.busy;
  assign valid_o        = ctrl.valid;
  assign ring_carry_b_o = carry_b;
  assign cnt_o          = cnt;
  assign ovf_o          = ovf;

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// tb/tb_ring_osc_ctrl.sv - self-checking bench for ring_osc_ctrl
module tb_ring_osc_ctrl;

  localparam int CW   = 4;
  localparam int WW   = 16;
  localparam int S    = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [WW-1:0] win_len_i = '0;
  logic          ring_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          ring_rstb_o, ring_tsc_o, ring_carry_b_o, ring_re_o;
  logic          busy_o, valid_o, ovf_o;
  logic [CW-1:0] cnt_o;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ring_half = 3;
  int ph = 0;
  bit hist [int];

  typedef struct {
    int win;
    int half;
    int lo;
    int hi;
    int ovf;
    int restart_at;
  } vec_t;

  vec_t vecs [7];

  ring_osc_ctrl #(.CNT_W(CW), .WIN_W(WW), .SETTLE(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .win_len_i      (win_len_i),
    .ring_i         (ring_i),
    .ring_rstb_o    (ring_rstb_o),
    .ring_tsc_o     (ring_tsc_o),
    .ring_carry_b_o (ring_carry_b_o),
    .ring_re_o      (ring_re_o),
    .busy_o         (busy_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .cnt_o          (cnt_o),
    .ovf_o          (ovf_o)
  );

  always #5 clk = ~clk;

  // Edge index and the ring level seen at that edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    hist[cyc] = ring_i;
  end

  // Ring source: square wave with a half period of ring_half clocks, or noise when >= 7
  always @(negedge clk) begin
    if (ring_half >= 7) begin
      ring_i = 1'($urandom_range(0, 1));
    end else if (ring_half > 0) begin
      ph = ph + 1;
      if (ph >= ring_half) begin
        ph = 0;
        ring_i = ~ring_i;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // Rising edges the controller should see: a 0->1 step in the ring samples
  // becomes visible two edges later (two sync stages), and it is counted on the
  // edges closing RUN and DRAIN, i.e. edges a+S+1 .. a+S+w+3 after the start edge a.
  function automatic int model_count(int a, int w);
    int n = 0;
    for (int k = a + S + 1; k <= a + S + w + 3; k++)
      if (hist[k-2] && !hist[k-3]) n++;
    return n;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " rstb"}, ring_rstb_o, 0);
    check({tag, " tsc"}, ring_tsc_o, 0);
    check({tag, " carry_b"}, ring_carry_b_o, 1);
    check({tag, " re"}, ring_re_o, 1);
    check({tag, " busy"}, busy_o, 0);
    check({tag, " valid"}, valid_o, 0);
    check({tag, " cnt"}, cnt_o, 0);
    check({tag, " ovf"}, ovf_o, 0);
  endtask

  task automatic measure(input int w, input int rdy_delay, input int restart_at,
                         input bit start_on_ack, input string tag,
                         output int got_cnt, output int got_ovf);
    int a;
    int lat;
    int n;
    bit hold_ok;
    logic [CW-1:0] held_cnt;
    logic held_ovf;
    @(negedge clk);
    start_i = 1'b1;
    win_len_i = WW'(w);
    ready_i = (rdy_delay == 0);
    @(posedge clk); #1;
    a = cyc;
    start_i = 1'b0;
    check({tag, " busy_after_start"}, busy_o, 1);
    lat = 1;
    while (!valid_o && lat < 1 + S + w + 3 + 20) begin
      if (lat == restart_at) begin
        start_i = 1'b1;
        win_len_i = WW'(w + 7);
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_i = 1'b0;
    check({tag, " latency"}, lat, 1 + S + w + 3);
    n = model_count(a, w);
    check({tag, " cnt"}, cnt_o, (n > CMAX) ? CMAX : n);
    check({tag, " ovf"}, ovf_o, (n > CMAX) ? 1 : 0);
    check({tag, " carry_b_done"}, ring_carry_b_o, (n > CMAX) ? 0 : 1);
    got_cnt = cnt_o;
    got_ovf = ovf_o;
    held_cnt = cnt_o;
    held_ovf = ovf_o;
    hold_ok = 1'b1;
    for (int i = 0; i < rdy_delay; i++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b1 || ring_rstb_o !== 1'b0 || cnt_o !== held_cnt || ovf_o !== held_ovf)
        hold_ok = 1'b0;
    end
    if (rdy_delay > 0) check({tag, " done_hold"}, hold_ok, 1);
    ready_i = 1'b1;
    if (start_on_ack) begin
      start_i = 1'b1;
      win_len_i = WW'(10);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    ready_i = 1'b0;
    check({tag, " valid_after_ack"}, valid_o, 0);
    check({tag, " busy_after_ack"}, busy_o, 0);
    check({tag, " carry_b_idle"}, ring_carry_b_o, 1);
    if (start_on_ack) begin
      @(posedge clk); #1;
      check({tag, " start_on_ack_ignored"}, busy_o, 0);
    end
    check({tag, " cnt_kept_idle"}, cnt_o, held_cnt);
  endtask

  initial begin
    int c;
    int o;
    bit ok;
    logic [CW-1:0] prev_cnt;

    vecs[0] = '{win: 60,  half: 3, lo: 9,  hi: 11, ovf: 0, restart_at: 20};
    vecs[1] = '{win: 100, half: 2, lo: 15, hi: 15, ovf: 1, restart_at: -1};
    vecs[2] = '{win: 30,  half: 3, lo: 5,  hi: 6,  ovf: 0, restart_at: -1};
    vecs[3] = '{win: 1,   half: 5, lo: 0,  hi: 1,  ovf: 0, restart_at: -1};
    vecs[4] = '{win: 20,  half: 1, lo: 11, hi: 12, ovf: 0, restart_at: -1};
    vecs[5] = '{win: 29,  half: 1, lo: 15, hi: 15, ovf: 1, restart_at: -1};
    vecs[6] = '{win: 26,  half: 1, lo: 14, hi: 15, ovf: 0, restart_at: -1};

    #2 rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 7; i++) begin
      ring_half = vecs[i].half;
      repeat (8) @(posedge clk);
      measure(vecs[i].win, (i == 2) ? 20 : (i % 3), vecs[i].restart_at, (i == 4),
              $sformatf("vec%0d", i), c, o);
      check_rng($sformatf("vec%0d cnt_range", i), c, vecs[i].lo, vecs[i].hi);
      check($sformatf("vec%0d ovf_flag", i), o, vecs[i].ovf);
    end

    prev_cnt = cnt_o;
    @(negedge clk);
    start_i = 1'b1;
    win_len_i = '0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy_o !== 1'b0 || valid_o !== 1'b0) ok = 1'b0;
    end
    start_i = 1'b0;
    check("win0_ignored", ok, 1);
    check("win0_cnt_kept", cnt_o, prev_cnt);

    ring_half = 3;
    @(negedge clk);
    start_i = 1'b1;
    win_len_i = WW'(40);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (S + 12) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_reset_vals("mid_run_reset");
    @(posedge clk); #1;
    check("mid_run_reset no_valid", valid_o, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    measure(25, 1, -1, 1'b0, "after_reset", c, o);

    for (int i = 0; i < 12; i++) begin
      ring_half = $urandom_range(1, 7);
      repeat (5) @(posedge clk);
      measure($urandom_range(1, 40), $urandom_range(0, 3), -1, 1'b0,
              $sformatf("rnd%0d", i), c, o);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
